// File: rtl/hbridge_deadtime_gate_if.sv
// rtl/hbridge_deadtime_gate_if.sv - command/gate bundle between ESC core, H-bridge gate stage and status readers
interface hbridge_deadtime_gate_if #(
    parameter int DT_WIDTH  = 8,
    parameter int ILL_WIDTH = 8
);
    logic                 en;
    logic                 cmd_pos;
    logic                 cmd_neg;
    logic [DT_WIDTH-1:0]  dead_cycles;
    logic                 brake;
    logic                 fault_n;
    logic                 fault_clear;
    logic                 gate_ah;
    logic                 gate_al;
    logic                 gate_bh;
    logic                 gate_bl;
    logic                 fault_latched;
    logic [2:0]           state_o;
    logic [ILL_WIDTH-1:0] illegal_cnt;

    modport master (
        output en, cmd_pos, cmd_neg, dead_cycles, brake, fault_n, fault_clear,
        input  gate_ah, gate_al, gate_bh, gate_bl, fault_latched, state_o, illegal_cnt
    );

    modport slave (
        input  en, cmd_pos, cmd_neg, dead_cycles, brake, fault_n, fault_clear,
        output gate_ah, gate_al, gate_bh, gate_bl, fault_latched, state_o, illegal_cnt
    );
endinterface

// File: rtl/hbridge_deadtime_gate.sv
// rtl/hbridge_deadtime_gate.sv - H-bridge gate driver with dead time, illegal-command reject and fault latch
// Optional active brake state enabled by defining HBRIDGE_BRAKE_EN.
module hbridge_deadtime_gate #(
    parameter int DT_WIDTH   = 8,
    parameter int FAULT_SYNC = 2,
    parameter int ILL_WIDTH  = 8
) (
    input logic                   clk,
    input logic                   reset,
    hbridge_deadtime_gate_if.slave bus
);
    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_DEAD  = 3'd1;
    localparam logic [2:0] ST_POS   = 3'd2;
    localparam logic [2:0] ST_NEG   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;
    localparam logic [2:0] ST_BRAKE = 3'd5;

    localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    logic [FAULT_SYNC-1:0] r_fault_sync;
    logic                  r_pos;
    logic                  r_neg;
    logic [2:0]            r_state;
    logic [DT_WIDTH-1:0]   r_dt_cnt;
    logic [ILL_WIDTH-1:0]  r_ill_cnt;
    logic                  r_gate_ah;
    logic                  r_gate_al;
    logic                  r_gate_bh;
    logic                  r_gate_bl;

    logic                  w_fault_ok;
    logic                  w_illegal;
    logic [2:0]            w_req;
    logic [2:0]            w_next;
    logic [DT_WIDTH-1:0]   w_cnt_next;
    logic [DT_WIDTH-1:0]   w_dead_load;

`ifdef HBRIDGE_BRAKE_EN
    logic                  r_brake;

    always_ff @(posedge clk) begin
        if (reset) r_brake <= 1'b0;
        else       r_brake <= bus.brake;
    end
`endif

    // Synchroniser resets to "no fault" so a reset never manufactures a fault.
    always_ff @(posedge clk) begin
        if (reset) r_fault_sync <= '1;
        else       r_fault_sync <= {r_fault_sync[FAULT_SYNC-2:0], bus.fault_n};
    end

    assign w_fault_ok  = r_fault_sync[FAULT_SYNC-1];
    assign w_illegal   = r_pos & r_neg;
    assign w_dead_load = (bus.dead_cycles == '0) ? DT_ONE : bus.dead_cycles;

    always_comb begin
        w_req = ST_OFF;
        if (bus.en) begin
            if (r_pos && !r_neg)      w_req = ST_POS;
            else if (r_neg && !r_pos) w_req = ST_NEG;
`ifdef HBRIDGE_BRAKE_EN
            if (r_brake)              w_req = ST_BRAKE;
`endif
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_dt_cnt;
        case (r_state)
            ST_OFF: begin
                if (w_req != ST_OFF) w_next = w_req;
            end
            ST_POS, ST_NEG: begin
                if (w_req != r_state) begin
                    w_next     = ST_DEAD;
                    w_cnt_next = w_dead_load;
                end
            end
            ST_DEAD: begin
                // Request changes during DEAD do not restart the count.
                if (r_dt_cnt <= DT_ONE) w_next = w_req;
                else                    w_cnt_next = r_dt_cnt - DT_ONE;
            end
            ST_FAULT: begin
                if (bus.fault_clear && w_fault_ok) w_next = ST_OFF;
            end
`ifdef HBRIDGE_BRAKE_EN
            ST_BRAKE: begin
                if (w_req == ST_OFF) begin
                    w_next = ST_OFF;
                end else if (w_req != ST_BRAKE) begin
                    w_next     = ST_DEAD;
                    w_cnt_next = w_dead_load;
                end
            end
`endif
            default: w_next = ST_OFF;
        endcase
        if (!w_fault_ok) w_next = ST_FAULT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos     <= 1'b0;
            r_neg     <= 1'b0;
            r_state   <= ST_OFF;
            r_dt_cnt  <= '0;
            r_ill_cnt <= '0;
            r_gate_ah <= 1'b0;
            r_gate_al <= 1'b0;
            r_gate_bh <= 1'b0;
            r_gate_bl <= 1'b0;
        end else begin
            r_pos     <= bus.cmd_pos;
            r_neg     <= bus.cmd_neg;
            r_state   <= w_next;
            r_dt_cnt  <= w_cnt_next;
            if (w_illegal && (r_ill_cnt != '1)) r_ill_cnt <= r_ill_cnt + 1'b1;
            // Gates come from the next-state decode so they track r_state exactly.
            r_gate_ah <= (w_next == ST_POS);
            r_gate_bh <= (w_next == ST_NEG);
            r_gate_al <= (w_next == ST_NEG) || (w_next == ST_BRAKE);
            r_gate_bl <= (w_next == ST_POS) || (w_next == ST_BRAKE);
        end
    end

    assign bus.gate_ah       = r_gate_ah;
    assign bus.gate_al       = r_gate_al;
    assign bus.gate_bh       = r_gate_bh;
    assign bus.gate_bl       = r_gate_bl;
    assign bus.fault_latched = (r_state == ST_FAULT);
    assign bus.state_o       = r_state;
    assign bus.illegal_cnt   = r_ill_cnt;
endmodule

// File: tb/tb_hbridge_deadtime_gate.sv
// tb/tb_hbridge_deadtime_gate.sv - directed vector bench for hbridge_deadtime_gate
module tb_hbridge_deadtime_gate;
    localparam logic [2:0] S_OFF = 3'd0, S_DEAD = 3'd1, S_POS = 3'd2, S_NEG = 3'd3, S_FAULT = 3'd4, S_BRAKE = 3'd5;
    localparam logic [3:0] G_NONE = 4'b0000, G_POS = 4'b1001, G_NEG = 4'b0110, G_BRK = 4'b0101;

    typedef struct {
        logic       en;
        logic       pos;
        logic       neg;
        logic [7:0] dead;
        int         cyc;
        logic [2:0] st;
        logic [3:0] g;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] prev_state = S_OFF;

    hbridge_deadtime_gate_if #(.DT_WIDTH(8), .ILL_WIDTH(8)) bus ();

    hbridge_deadtime_gate #(.DT_WIDTH(8), .FAULT_SYNC(2), .ILL_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gates();
        return {bus.gate_ah, bus.gate_al, bus.gate_bh, bus.gate_bl};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_dead(input logic [2:0] target, output int ndead, output bit reached);
        ndead   = 0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick();
            if (bus.state_o == S_DEAD) begin
                ndead++;
                chk("dead_gates_off", gates(), G_NONE);
            end else if (bus.state_o == target) begin
                reached = 1'b1;
            end
        end
    endtask

    // Invariant monitor: no shoot-through, no direct POS<->NEG step.
    always @(negedge clk) begin
        if (!reset) begin
            chk("shoot_through_a", bus.gate_ah & bus.gate_al, 1'b0);
            chk("shoot_through_b", bus.gate_bh & bus.gate_bl, 1'b0);
            chk("direct_pos_neg",
                ((prev_state == S_POS) && (bus.state_o == S_NEG)) ||
                ((prev_state == S_NEG) && (bus.state_o == S_POS)), 1'b0);
        end
        prev_state = bus.state_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int   nd;
        bit   ok;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd2, 3, S_OFF,  G_NONE};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'd2, 2, S_POS,  G_POS};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd2, 3, S_POS,  G_POS};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd2, 2, S_DEAD, G_NONE};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1, S_DEAD, G_NONE};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1, S_OFF,  G_NONE};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'd2, 2, S_NEG,  G_NEG};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'd1, 1, S_DEAD, G_NONE};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd1, 1, S_OFF,  G_NONE};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1, S_NEG,  G_NEG};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'd1, 1, S_NEG,  G_NEG};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'd1, 1, S_DEAD, G_NONE};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'd1, 1, S_OFF,  G_NONE};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8'd1, 3, S_OFF,  G_NONE};

        reset           = 1'b1;
        bus.en          = 1'b0;
        bus.cmd_pos     = 1'b0;
        bus.cmd_neg     = 1'b0;
        bus.dead_cycles = 8'd2;
        bus.brake       = 1'b0;
        bus.fault_n     = 1'b1;
        bus.fault_clear = 1'b0;
        tick(2);
        chk("reset_state", bus.state_o, S_OFF);
        chk("reset_gates", gates(), G_NONE);
        chk("reset_fault", bus.fault_latched, 1'b0);
        chk("reset_illegal", bus.illegal_cnt, 8'd0);
        reset = 1'b0;

        for (int v = 0; v < 14; v++) begin
            bus.en          = vecs[v].en;
            bus.cmd_pos     = vecs[v].pos;
            bus.cmd_neg     = vecs[v].neg;
            bus.dead_cycles = vecs[v].dead;
            tick(vecs[v].cyc);
            chk($sformatf("vec%0d_state", v), bus.state_o, vecs[v].st);
            chk($sformatf("vec%0d_gates", v), gates(), vecs[v].g);
        end

        // Five-cycle dead time POS -> NEG
        bus.en = 1'b1; bus.cmd_pos = 1'b1; bus.cmd_neg = 1'b0; bus.dead_cycles = 8'd5;
        tick(3);
        chk("dt5_start_pos", bus.state_o, S_POS);
        bus.cmd_pos = 1'b0; bus.cmd_neg = 1'b1;
        count_dead(S_NEG, nd, ok);
        chk("dt5_reached", ok, 1'b1);
        chk("dt5_dead_cycles", nd, 5);
        chk("dt5_gates", gates(), G_NEG);

        // Zero dead time behaves as one cycle
        bus.dead_cycles = 8'd0; bus.cmd_pos = 1'b1; bus.cmd_neg = 1'b0;
        count_dead(S_POS, nd, ok);
        chk("dt0_reached", ok, 1'b1);
        chk("dt0_dead_cycles", nd, 1);
        chk("dt0_gates", gates(), G_POS);

        // Brake request from POS
        bus.dead_cycles = 8'd3; bus.brake = 1'b1;
`ifdef HBRIDGE_BRAKE_EN
        count_dead(S_BRAKE, nd, ok);
        chk("brake_reached", ok, 1'b1);
        chk("brake_dead_cycles", nd, 3);
        chk("brake_gates", gates(), G_BRK);
`else
        tick(10);
        chk("brake_ignored_state", bus.state_o, S_POS);
        chk("brake_ignored_gates", gates(), G_POS);
`endif

        // Mid-operation reset, then illegal-command saturation
        reset = 1'b1; bus.brake = 1'b0;
        tick();
        chk("midreset_state", bus.state_o, S_OFF);
        chk("midreset_gates", gates(), G_NONE);
        chk("midreset_illegal", bus.illegal_cnt, 8'd0);
        reset = 1'b0;
        bus.cmd_pos = 1'b1; bus.cmd_neg = 1'b1;
        tick(3);
        chk("illegal_early", bus.illegal_cnt, 8'd2);
        tick(297);
        chk("illegal_saturated", bus.illegal_cnt, 8'd255);
        chk("illegal_gates", gates(), G_NONE);
        chk("illegal_state", bus.state_o, S_OFF);

        // Fault latch and clear
        bus.cmd_pos = 1'b0; bus.cmd_neg = 1'b1; bus.dead_cycles = 8'd2;
        tick(3);
        chk("fault_pre_neg", bus.state_o, S_NEG);
        bus.fault_n = 1'b0;
        tick();
        bus.fault_n = 1'b1;
        tick();
        chk("fault_not_yet", bus.state_o, S_NEG);
        tick();
        chk("fault_state", bus.state_o, S_FAULT);
        chk("fault_gates", gates(), G_NONE);
        chk("fault_latched", bus.fault_latched, 1'b1);
        tick(5);
        chk("fault_held", bus.fault_latched, 1'b1);
        bus.fault_n = 1'b0;
        tick(3);
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        chk("fault_clear_blocked", bus.state_o, S_FAULT);
        bus.fault_n = 1'b1;
        tick(3);
        chk("fault_wait_clear", bus.state_o, S_FAULT);
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        chk("fault_cleared_state", bus.state_o, S_OFF);
        chk("fault_cleared_flag", bus.fault_latched, 1'b0);
        tick();
        chk("fault_resume_state", bus.state_o, S_NEG);
        chk("fault_resume_gates", gates(), G_NEG);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
